// File: rtl/pgmflash_seq.sv
// Program-flash access sequencer: borrows the Z80 bus, then runs one timed ROM read or write.
// Optional build macro PGMFLASH_AUTOINC_EN enables address auto-increment after each access.
module pgmflash_seq #(
    parameter int ACC_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        addr_ld,
    input  logic [7:0]  addr_din,
    input  logic        phase_rst,
    input  logic        autoinc,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        overrun,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic [18:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_doe,
    input  logic [7:0]  mem_din,
    output logic        romcs_n,
    output logic        memoe_n,
    output logic        memwe_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BREQ  = 3'd1,
        ST_SETUP = 3'd2,
        ST_STRB  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_BREL  = 3'd5
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

    state_t      state_r, state_nxt_s;
    logic [18:0] addr_r, mem_a_r;
    logic [1:0]  phase_r;
    logic [3:0]  cnt_r;
    logic        op_wr_r, op_inc_r, ld_seen_r;
    logic [7:0]  op_data_r, rd_data_r, mem_dout_r;
    logic        pend_r, pend_wr_r, pend_inc_r;
    logic [7:0]  pend_data_r;
    logic        overrun_r, busrq_n_r, romcs_n_r, memoe_n_r, memwe_n_r, mem_doe_r;
    logic        new_req_s, inc_req_s;
    logic        start_s, start_wr_s, start_inc_s, store_s, drop_s;
    logic [7:0]  start_data_s;

    function automatic logic owns_bus(input state_t s);
        return (s == ST_BREQ) || (s == ST_SETUP) || (s == ST_STRB) || (s == ST_HOLD);
    endfunction

    function automatic logic rom_sel(input state_t s);
        return (s == ST_SETUP) || (s == ST_STRB) || (s == ST_HOLD);
    endfunction

`ifdef PGMFLASH_AUTOINC_EN
    assign inc_req_s = autoinc;
`else
    assign inc_req_s = autoinc & 1'b0;
`endif

    assign new_req_s = rd_req | wr_req;

    // Request arbitration: start from IDLE (pending slot first), otherwise queue or drop
    always_comb begin
        start_s      = 1'b0;
        start_wr_s   = 1'b0;
        start_inc_s  = 1'b0;
        start_data_s = 8'h00;
        store_s      = 1'b0;
        drop_s       = 1'b0;
        if (state_r == ST_IDLE) begin
            if (pend_r) begin
                start_s      = 1'b1;
                start_wr_s   = pend_wr_r;
                start_inc_s  = pend_inc_r;
                start_data_s = pend_data_r;
                store_s      = new_req_s;
            end else if (new_req_s) begin
                start_s      = 1'b1;
                start_wr_s   = wr_req;
                start_inc_s  = inc_req_s;
                start_data_s = wr_req ? wr_data : 8'h00;
            end else begin
                start_s = 1'b0;
            end
        end else begin
            if (new_req_s && !pend_r) begin
                store_s = 1'b1;
            end else begin
                drop_s = new_req_s;
            end
        end
    end

    // Access FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_s)         state_nxt_s = ST_BREQ;  else state_nxt_s = ST_IDLE;
            ST_BREQ:  if (!busak_n)        state_nxt_s = ST_SETUP; else state_nxt_s = ST_BREQ;
            ST_SETUP:                      state_nxt_s = ST_STRB;
            ST_STRB:  if (cnt_r == 4'd0)   state_nxt_s = ST_HOLD;  else state_nxt_s = ST_STRB;
            ST_HOLD:                       state_nxt_s = ST_BREL;
            ST_BREL:  if (busak_n)         state_nxt_s = ST_IDLE;  else state_nxt_s = ST_BREL;
            default:                       state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, strobe counter, active/pending operation and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            op_wr_r     <= 1'b0;
            op_inc_r    <= 1'b0;
            op_data_r   <= 8'h00;
            pend_r      <= 1'b0;
            pend_wr_r   <= 1'b0;
            pend_inc_r  <= 1'b0;
            pend_data_r <= 8'h00;
            overrun_r   <= 1'b0;
            rd_data_r   <= 8'hFF;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_SETUP) begin
                cnt_r <= CNT_LAST;
            end else if (state_r == ST_STRB) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (start_s) begin
                op_wr_r   <= start_wr_s;
                op_inc_r  <= start_inc_s;
                op_data_r <= start_data_s;
            end
            if (store_s) begin
                pend_r      <= 1'b1;
                pend_wr_r   <= wr_req;
                pend_inc_r  <= inc_req_s;
                pend_data_r <= wr_req ? wr_data : 8'h00;
            end else if (start_s) begin
                pend_r <= 1'b0;
            end
            if (drop_s || (rd_req && wr_req)) begin
                overrun_r <= 1'b1;
            end
            if ((state_r == ST_STRB) && (cnt_r == 4'd0) && !op_wr_r) begin
                rd_data_r <= mem_din;
            end
        end
    end

    // Address register: byte-wise loading, phase tracking and post-access increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r    <= 19'h00000;
            phase_r   <= 2'd0;
            ld_seen_r <= 1'b0;
        end else begin
            if (addr_ld) begin
                case (phase_r)
                    2'd0:    addr_r[7:0]   <= addr_din;
                    2'd1:    addr_r[15:8]  <= addr_din;
                    2'd2:    addr_r[18:16] <= addr_din[2:0];
                    default: addr_r        <= addr_r;
                endcase
            end else if ((state_r == ST_HOLD) && op_inc_r && !ld_seen_r) begin
                addr_r <= addr_r + 19'd1;
            end
            if (phase_rst || rd_req || wr_req) begin
                phase_r <= 2'd0;
            end else if (addr_ld) begin
                case (phase_r)
                    2'd0:    phase_r <= 2'd1;
                    2'd1:    phase_r <= 2'd2;
                    default: phase_r <= 2'd0;
                endcase
            end
            // A load during an access cancels that access's increment so the new address stands
            if (start_s) begin
                ld_seen_r <= 1'b0;
            end else if (addr_ld) begin
                ld_seen_r <= 1'b1;
            end
        end
    end

    // Registered bus and ROM outputs, decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busrq_n_r  <= 1'b1;
            romcs_n_r  <= 1'b1;
            memoe_n_r  <= 1'b1;
            memwe_n_r  <= 1'b1;
            mem_doe_r  <= 1'b0;
            mem_a_r    <= 19'h00000;
            mem_dout_r <= 8'h00;
        end else begin
            busrq_n_r <= !owns_bus(state_nxt_s);
            romcs_n_r <= !rom_sel(state_nxt_s);
            memoe_n_r <= !((state_nxt_s == ST_STRB) && !op_wr_r);
            memwe_n_r <= !((state_nxt_s == ST_STRB) && op_wr_r);
            mem_doe_r <= rom_sel(state_nxt_s) && op_wr_r;
            if ((state_r == ST_BREQ) && (state_nxt_s == ST_SETUP)) begin
                mem_a_r    <= addr_r;
                mem_dout_r <= op_data_r;
            end
        end
    end

    // Losing the bus grant forces every ROM strobe inactive without waiting for a clock
    assign romcs_n  = romcs_n_r | busak_n;
    assign memoe_n  = memoe_n_r | busak_n;
    assign memwe_n  = memwe_n_r | busak_n;
    assign busrq_n  = busrq_n_r;
    assign mem_doe  = mem_doe_r;
    assign mem_a    = mem_a_r;
    assign mem_dout = mem_dout_r;
    assign rd_data  = rd_data_r;
    assign overrun  = overrun_r;
    assign busy     = (state_r != ST_IDLE) | pend_r;

endmodule
